// File: rtl/filter_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : filter_stream_if
// Purpose  : Bundles the three handshaked channels of filter_stream:
//            kernel configuration, upstream pixel columns and downstream
//            filtered results.
// Ports    : cfg_ker/cfg_val/cfg_rdy        - kernel tap load channel
//            up_img/up_last/up_val/up_rdy   - column input stream
//            dn_data/dn_last/dn_val/dn_rdy  - result output stream
// Modports : master - the side that drives taps/columns and accepts results
//            slave  - the filter engine itself
// Revision : 1.0 - initial release
// ============================================================================
interface filter_stream_if #(
  parameter int HEIGHT_NB = 3,
  parameter int IMG_WIDTH = 8,
  parameter int KER_WIDTH = 16,
  parameter int OUT_WIDTH = 16
);
  logic [KER_WIDTH-1:0]           cfg_ker;
  logic                           cfg_val;
  logic                           cfg_rdy;
  logic [HEIGHT_NB*IMG_WIDTH-1:0] up_img;
  logic                           up_last;
  logic                           up_val;
  logic                           up_rdy;
  logic [OUT_WIDTH-1:0]           dn_data;
  logic                           dn_last;
  logic                           dn_val;
  logic                           dn_rdy;

  modport master (
    output cfg_ker, cfg_val, up_img, up_last, up_val, dn_rdy,
    input  cfg_rdy, up_rdy, dn_data, dn_last, dn_val
  );

  modport slave (
    input  cfg_ker, cfg_val, up_img, up_last, up_val, dn_rdy,
    output cfg_rdy, up_rdy, dn_data, dn_last, dn_val
  );
endinterface
`default_nettype wire

// File: rtl/filter_stream.sv
`default_nettype none
// ============================================================================
// Module   : filter_stream
// Purpose  : Streaming HEIGHT_NB x WIDTH_NB 2-D convolution engine. Kernel
//            taps are loaded over the cfg channel, pixel columns fill a
//            sliding window, and each full window yields one shifted sum
//            through a three-stage pipeline (products, sum, output).
// Ports    : clk, rst (synchronous, active-high)
//            bus (filter_stream_if.slave) - cfg, upstream and downstream
// Options  : FILTER_SAT_EN - when defined, the shifted sum saturates to the
//            signed OUT_WIDTH range; otherwise it wraps (low bits kept).
// Revision : 1.0 - initial release
// ============================================================================
module filter_stream #(
  parameter int HEIGHT_NB = 3,
  parameter int WIDTH_NB  = 3,
  parameter int IMG_WIDTH = 8,
  parameter int KER_WIDTH = 16,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8
) (
  input  logic           clk,
  input  logic           rst,
  filter_stream_if.slave bus
);

  localparam int MAC_NB     = HEIGHT_NB * WIDTH_NB;
  localparam int PROD_WIDTH = IMG_WIDTH + 1 + KER_WIDTH;
  localparam int ACC_WIDTH  = PROD_WIDTH + $clog2(MAC_NB);
  localparam int K_WIDTH    = (MAC_NB > 1) ? $clog2(MAC_NB) : 1;
  localparam int F_WIDTH    = $clog2(WIDTH_NB + 1);

  localparam logic [K_WIDTH-1:0] K_LAST    = K_WIDTH'(MAC_NB - 1);
  localparam logic [F_WIDTH-1:0] FILL_FULL = F_WIDTH'(WIDTH_NB);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic                         cfg_rdy, up_rdy;
  logic                         cfg_acc, up_acc;
  logic                         en, pipe_empty;
  logic [K_WIDTH-1:0]           k, tap_idx;
  logic signed [KER_WIDTH-1:0]  tap [MAC_NB];

  logic [IMG_WIDTH-1:0]         win     [HEIGHT_NB][WIDTH_NB];
  logic [IMG_WIDTH-1:0]         win_nxt [HEIGHT_NB][WIDTH_NB];
  logic [F_WIDTH-1:0]           fill, fill_inc;
  logic                         emit;

  logic signed [PROD_WIDTH-1:0] prod    [MAC_NB];
  logic signed [ACC_WIDTH-1:0]  s1_prod [MAC_NB];
  logic signed [ACC_WIDTH-1:0]  sum, s2_sum, shifted;
  logic signed [OUT_WIDTH-1:0]  reduced;

  logic                         win_val, win_last;
  logic                         s1_val, s1_last;
  logic                         s2_val, s2_last;
  logic                         res_val, res_last;
  logic signed [OUT_WIDTH-1:0]  res_data;

  // The whole datapath advances together; a stalled output freezes
  // the window and every pipeline stage behind it.
  assign en         = !res_val || bus.dn_rdy;
  assign pipe_empty = !(win_val || s1_val || s2_val || res_val);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_rdy   = 1'b0;
    up_rdy    = 1'b0;
    case (state)
      LOAD: begin
        cfg_rdy = 1'b1;
        if (bus.cfg_val && (k == K_LAST)) state_nxt = RUN;
      end
      RUN: begin
        // A reload may only start once no result computed with the old
        // taps is still in flight.
        cfg_rdy = pipe_empty;
        up_rdy  = en;
        if (bus.cfg_val && pipe_empty) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign cfg_acc = bus.cfg_val && cfg_rdy;
  assign up_acc  = bus.up_val && up_rdy;

  // --------------------------------------------------------------------------
  // Tap storage: a word accepted in RUN restarts the load at tap 0.
  // --------------------------------------------------------------------------
  assign tap_idx = (state == LOAD) ? k : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
    end else if (cfg_acc) begin
      if (state == RUN)     k <= K_WIDTH'(1);
      else if (k == K_LAST) k <= '0;
      else                  k <= k + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_acc) tap[tap_idx] <= bus.cfg_ker;
  end

  // --------------------------------------------------------------------------
  // Sliding window and per-tap multipliers
  // --------------------------------------------------------------------------
  for (genvar h = 0; h < HEIGHT_NB; h++) begin : g_row
    for (genvar w = 0; w < WIDTH_NB; w++) begin : g_col
      if (w == WIDTH_NB - 1) begin : g_newest
        assign win_nxt[h][w] = bus.up_img[h*IMG_WIDTH +: IMG_WIDTH];
      end else begin : g_older
        assign win_nxt[h][w] = win[h][w+1];
      end
      // Pixel is zero-extended, tap sign-extended; the product always fits.
      assign prod[h*WIDTH_NB+w] = $signed(PROD_WIDTH'({1'b0, win[h][w]}))
                                * $signed(PROD_WIDTH'(tap[h*WIDTH_NB+w]));
    end
  end

  always_ff @(posedge clk) begin
    if (up_acc) win <= win_nxt;
  end

  assign fill_inc = (fill == FILL_FULL) ? fill : fill + 1'b1;
  assign emit     = (fill_inc == FILL_FULL);

  // --------------------------------------------------------------------------
  // Pipeline: S1 products, S2 sum, S3 output register
  // --------------------------------------------------------------------------
  always_comb begin
    sum = '0;
    for (int i = 0; i < MAC_NB; i++) sum = sum + s1_prod[i];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < MAC_NB; i++) s1_prod[i] <= ACC_WIDTH'(prod[i]);
      s2_sum <= sum;
    end
  end

  assign shifted = s2_sum >>> SHIFT;

`ifdef FILTER_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  always_comb begin
    reduced = shifted[OUT_WIDTH-1:0];
    if (shifted > OUT_MAX)      reduced = OUT_MAX[OUT_WIDTH-1:0];
    else if (shifted < OUT_MIN) reduced = OUT_MIN[OUT_WIDTH-1:0];
  end
`else
  // Wrap mode keeps only the low bits; the upper ones are intentionally dropped.
  logic unused_shift_hi;
  assign unused_shift_hi = ^shifted[ACC_WIDTH-1:OUT_WIDTH];
  assign reduced         = shifted[OUT_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fill     <= '0;
      win_val  <= 1'b0;
      win_last <= 1'b0;
      s1_val   <= 1'b0;
      s1_last  <= 1'b0;
      s2_val   <= 1'b0;
      s2_last  <= 1'b0;
      res_val  <= 1'b0;
      res_last <= 1'b0;
      res_data <= '0;
    end else begin
      if (cfg_acc && (state == RUN)) fill <= '0;
      else if (up_acc)               fill <= bus.up_last ? '0 : fill_inc;

      if (en) begin
        win_val  <= up_acc && emit;
        win_last <= up_acc && emit && bus.up_last;
        s1_val   <= win_val;
        s1_last  <= win_last;
        s2_val   <= s1_val;
        s2_last  <= s1_last;
        res_val  <= s2_val;
        res_last <= s2_last;
        if (s2_val) res_data <= reduced;
      end
    end
  end

  assign bus.cfg_rdy = cfg_rdy;
  assign bus.up_rdy  = up_rdy;
  assign bus.dn_data = res_data;
  assign bus.dn_val  = res_val;
  assign bus.dn_last = res_last;

endmodule
`default_nettype wire

// File: doc/filter_stream.md
# filter_stream

Streaming 2-D convolution engine, the parametrised successor to the fixed-size row-MAC filter. Kernel taps are loaded through a handshaked config port. Image columns of HEIGHT_NB pixels arrive on a valid/ready stream and fill a WIDTH_NB-column sliding window. Each full window produces one fully summed, shifted output on a backpressure-aware downstream port. The block sits between the line-buffer column generator and the output packer.

## Interface
- HEIGHT_NB, 3, kernel rows (pixels per input column)
- WIDTH_NB, 3, kernel columns (window depth)
- IMG_WIDTH, 8, unsigned pixel width
- KER_WIDTH, 16, signed kernel tap width
- OUT_WIDTH, 16, signed output width
- SHIFT, 8, arithmetic right shift applied to the sum before output
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_ker  in  KER_WIDTH  kernel tap word
- cfg_val  in  1  tap word valid
- cfg_rdy  out  1  tap word accepted when cfg_val & cfg_rdy
- up_img  in  HEIGHT_NB*IMG_WIDTH  column; row h at bits [h*IMG_WIDTH +: IMG_WIDTH]
- up_last  in  1  column is last of image row; qualified by up_val & up_rdy
- up_val  in  1  column valid
- up_rdy  out  1  column accepted when up_val & up_rdy
- dn_data  out  OUT_WIDTH  filtered result
- dn_last  out  1  result belongs to last window of image row
- dn_val  out  1  result valid
- dn_rdy  in  1  downstream ready

## Operation
- MAC_NB = HEIGHT_NB*WIDTH_NB. ACC_WIDTH = IMG_WIDTH+1+KER_WIDTH+clog2(MAC_NB). All accumulation is at ACC_WIDTH, signed. Pixels are zero-extended.
- FSM states: LOAD and RUN. Reset enters LOAD with tap index 0.
- LOAD:
  - cfg_rdy=1, up_rdy=0.
  - Each accepted word writes tap[k], where k = h*WIDTH_NB + w, then k increments.
  - When word k = MAC_NB-1 is accepted, move to RUN and set k = 0.
- RUN:
  - cfg_rdy=1 only when all pipeline stages are empty and dn_val=0.
  - An accepted cfg word writes tap[0], moves to LOAD with k=1, and clears the window fill count.
- Window:
  - An accepted column shifts in at w=WIDTH_NB-1 (newest). w=0 holds the oldest column.
  - fill counts 0..WIDTH_NB and saturates at WIDTH_NB.
  - A window is emitted on each accepted column for which fill reaches or stays at WIDTH_NB.
  - up_last on an accepted column marks that column's window (if one is emitted) as last, then clears fill to 0 for the next row.
- Result = (sum over h,w of pixel[h][w]*tap[h*WIDTH_NB+w]) >>> SHIFT, reduced to OUT_WIDTH per the Configuration section.
- Pipeline stages: S1 registers the products, S2 registers the adder-tree sum, S3 is the output register (dn_data/dn_val/dn_last).
- Global enable en = !dn_val | dn_rdy. When en=0, the window, S1, S2 and S3 all hold. up_rdy = (state==RUN) & en.

## Timing
- Reset values:
  - state=LOAD, k=0, fill=0, all stage valids 0.
  - dn_val=0, dn_data=0, dn_last=0.
  - cfg_rdy=1, up_rdy=0.
  - Tap registers are not reset.
- Latency: a column accepted at edge N that completes a window gives dn_val=1 after edge N+3, with no stalls.
- Throughput: one result per clock when up_val=dn_rdy=1.
- dn_val, dn_data and dn_last stay stable while dn_val & !dn_rdy.
- A transfer and a new result in the same cycle is legal: S3 reloads on the same edge.
- cfg_val in RUN with a non-empty pipeline is ignored (cfg_rdy=0). The sender holds the word.
- up_last on a column that does not complete a window produces no output. Fill still clears.
- rst mid-stream: all in-flight results are discarded and the kernel must be reloaded.

## Configuration
- FILTER_SAT_EN defined: the shifted sum saturates to the signed OUT_WIDTH range, [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Not defined: the shifted sum is truncated to its low OUT_WIDTH bits (two's-complement wrap).

## Test plan
- 3x3, SHIFT=0. All taps=1, stream of columns with every pixel=2, dn_rdy=1 → first dn_val 3 cycles after the 3rd accepted column, dn_data=18, then 18 every cycle.
- Taps k=0..8 = 1..9, columns c0={1,1,1}, c1={2,2,2}, c2={3,3,3} → dn_data = 1*(1+4+7) + 2*(2+5+8) + 3*(3+6+9) = 96.
- dn_rdy held 0 for 5 cycles mid-stream → up_rdy=0 and dn_data constant during the stall. No result is lost or duplicated after release; the output sequence matches the reference model.
- up_last on the 4th column of a row → exactly 2 results, the 2nd with dn_last=1. The next row yields its first result only after 3 more columns.
- Taps=32767, pixels=255, SHIFT=0, OUT_WIDTH=16 → with FILTER_SAT_EN, dn_data=32767. Without it, dn_data = low 16 bits of 9*255*32767.
- cfg_val asserted in RUN while results are in flight → cfg_rdy=0 until drained. Reloading all taps with 0 then gives dn_data=0. Assert rst mid-stream → dn_val=0 next cycle and up_rdy=0 until 9 new taps are loaded.
